// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the HI/LO multiply/divide sequencer:
//   - Op code encodings seen on the decode interface
//   - FSM state encoding and the latched operation class
//   - helper that sizes the iteration counter from WIDTH
// MADD/MSUB codes are always defined here; whether they are accepted is
// decided by the HILO_MADD_EN build macro in hilo_muldiv_ctrl.
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef logic [2:0] op_t;

    localparam op_t OP_MULT  = 3'd0;
    localparam op_t OP_MULTU = 3'd1;
    localparam op_t OP_DIV   = 3'd2;
    localparam op_t OP_DIVU  = 3'd3;
    localparam op_t OP_MTHI  = 3'd4;
    localparam op_t OP_MTLO  = 3'd5;
    localparam op_t OP_MADD  = 3'd6;
    localparam op_t OP_MSUB  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Class of the in-flight iterative op; selects the commit rule in FIX.
    typedef enum logic [1:0] {
        K_MUL  = 2'd0,
        K_DIV  = 2'd1,
        K_MADD = 2'd2,
        K_MSUB = 2'd3
    } kind_e;

    // Counter holds 0 .. width-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// ---------------------------------------------------------------------------
// muldiv_iter_core
// Radix-2 datapath: one shift/add (multiply) or shift/subtract (restoring
// divide) step per cycle on unsigned magnitudes.
//   Multiply: hi accumulates, lo holds the multiplier and shifts right;
//             after WIDTH steps {hi,lo} is the 2*WIDTH-bit product.
//   Divide:   lo holds the dividend and shifts left collecting quotient
//             bits; hi is the partial remainder.
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   load_i         load operands, clear hi (has priority over step_i)
//   step_i         perform one iteration
//   is_div_i       mode captured at load: 1 = divide, 0 = multiply
//   mcand_i        multiplicand (multiply) or divisor (divide)
//   seed_i         multiplier (multiply) or dividend (divide)
//   hi_o, lo_o     working registers; final product or remainder/quotient
// ---------------------------------------------------------------------------
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] m_q,  m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_q, div_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;

        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        shifted = {hi_q, lo_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, m_q});
        // Only used when ge, where the true difference fits in WIDTH bits.
        diff    = shifted[WIDTH-1:0] - m_q;

        if (load_i) begin
            m_d   = mcand_i;
            hi_d  = '0;
            lo_d  = seed_i;
            div_d = is_div_i;
        end else if (step_i) begin
            if (div_q) begin
                hi_d = ge ? diff : shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], ge};
            end else begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            m_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            div_q <= 1'b0;
        end else begin
            m_q   <= m_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            div_q <= div_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_ctrl
// Sequencer for the HI/LO multiply/divide unit. MTHI/MTLO write in one cycle;
// MULT/MULTU/DIV/DIVU run WIDTH radix-2 iterations in muldiv_iter_core, then
// a FIX cycle applies sign correction and commits HI/LO. Done pulses the
// cycle after the commit. Stall holds decode while the unit is busy and a new
// op or an MFHI/MFLO read is presented.
// Build option: define HILO_MADD_EN to accept MADD/MSUB (signed
// {Hi,Lo} +/- OpA*OpB, same latency); otherwise those codes are ignored.
// Ports
//   Clk        clock, rising edge
//   Reset      asynchronous active-high reset; drops any in-flight op
//   Start      op request, qualified by Op; only accepted in IDLE
//   Op         op code (muldiv_pkg OP_*)
//   OpA, OpB   rs / rt operands
//   HiLoRead   MFHI/MFLO in decode this cycle
//   Stall      Busy & (Start | HiLoRead)
//   Busy       high in RUN and FIX
//   Done       one-cycle pulse after an iterative op commits HI/LO
//   Hi, Lo     architectural HI/LO registers
// ---------------------------------------------------------------------------
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             HiLoRead,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int               CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    kind_e              kind_q, kind_d;
    logic               neg_q, neg_d;          // negate product / quotient
    logic               rem_neg_q, rem_neg_d;  // negate remainder
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Decode of the presented op
    logic               is_div, is_signed, is_iter, div_zero;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b, mcand, seed;
    kind_e              kind_dec;
    logic               accept;

    logic [WIDTH-1:0]   core_hi, core_lo;
    logic [2*WIDTH-1:0] prod_s;

    always_comb begin
        is_div    = (Op == OP_DIV) || (Op == OP_DIVU);
        is_signed = (Op == OP_MULT) || (Op == OP_DIV);
        is_iter   = (Op == OP_MULT) || (Op == OP_MULTU) || is_div;
        kind_dec  = is_div ? K_DIV : K_MUL;
`ifdef HILO_MADD_EN
        if (Op == OP_MADD) begin
            is_signed = 1'b1;
            is_iter   = 1'b1;
            kind_dec  = K_MADD;
        end
        if (Op == OP_MSUB) begin
            is_signed = 1'b1;
            is_iter   = 1'b1;
            kind_dec  = K_MSUB;
        end
`endif
        // Divide by zero runs on the raw dividend with no sign fix-up: the
        // restoring loop then yields quotient all-ones and remainder = OpA.
        div_zero = is_div && (OpB == '0);
        a_neg    = is_signed && OpA[WIDTH-1] && !div_zero;
        b_neg    = is_signed && OpB[WIDTH-1];
        abs_a    = a_neg ? -OpA : OpA;
        abs_b    = b_neg ? -OpB : OpB;
        mcand    = is_div ? abs_b : abs_a;
        seed     = is_div ? abs_a : abs_b;
    end

    assign accept = (state_q == S_IDLE) && Start && is_iter;

    muldiv_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .load_i   (accept),
        .step_i   (state_q == S_RUN),
        .is_div_i (is_div),
        .mcand_i  (mcand),
        .seed_i   (seed),
        .hi_o     (core_hi),
        .lo_o     (core_lo)
    );

    // FSM: state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST_ITER) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        Busy  = (state_q == S_RUN) || (state_q == S_FIX);
        Stall = Busy && (Start || HiLoRead);
    end

    // Counter, latched sign flags and HI/LO commit
    always_comb begin
        cnt_d     = (state_q == S_RUN) ? cnt_q + 1'b1 : '0;
        kind_d    = kind_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = (state_q == S_FIX);
        prod_s    = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};

        if (accept) begin
            kind_d    = kind_dec;
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;          // remainder follows dividend sign
        end

        if ((state_q == S_IDLE) && Start && (Op == OP_MTHI)) hi_d = OpA;
        if ((state_q == S_IDLE) && Start && (Op == OP_MTLO)) lo_d = OpA;

        if (state_q == S_FIX) begin
            case (kind_q)
                K_DIV: begin
                    hi_d = rem_neg_q ? -core_hi : core_hi;
                    lo_d = neg_q ? -core_lo : core_lo;
                end
`ifdef HILO_MADD_EN
                K_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                K_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
`endif
                default: {hi_d, lo_d} = prod_s;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q     <= '0;
            kind_q    <= K_MUL;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            kind_q    <= kind_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Done = done_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_ctrl
// Self-checking bench for hilo_muldiv_ctrl (WIDTH = 32). Expected HI/LO come
// from a reference model using plain 64-bit arithmetic. Inputs are driven on
// the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [2:0]   Op;
    logic [W-1:0] OpA, OpB;
    logic         HiLoRead;
    logic         Stall, Busy, Done;
    logic [W-1:0] Hi, Lo;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [63:0]  exp_hilo;

    hilo_muldiv_ctrl #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Op       (Op),
        .OpA      (OpA),
        .OpB      (OpB),
        .HiLoRead (HiLoRead),
        .Stall    (Stall),
        .Busy     (Busy),
        .Done     (Done),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Architectural result of one op, returned as {Hi,Lo}.
    function automatic logic [63:0] ref_op(input op_t op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] hilo);
        longint      sa, sb, prod, q, rm;
        logic [63:0] r;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        prod = sa * sb;
        r    = hilo;
        case (op)
            OP_MULT:  r = 64'(prod);
            OP_MULTU: r = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
            OP_MTHI: r = {a, hilo[31:0]};
            OP_MTLO: r = {hilo[63:32], a};
`ifdef HILO_MADD_EN
            OP_MADD: r = hilo + 64'(prod);
            OP_MSUB: r = hilo - 64'(prod);
`endif
            default: r = hilo;
        endcase
        return r;
    endfunction

    function automatic bit tb_is_iter(input op_t op);
`ifdef HILO_MADD_EN
        return (op <= OP_DIVU) || (op == OP_MADD) || (op == OP_MSUB);
`else
        return (op <= OP_DIVU);
`endif
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Entered at the falling edge right after the accept edge, Start low.
    task automatic wait_result(input string tag, input logic [63:0] old_hilo);
        int n;
        check({tag, ".busy"}, 64'(Busy), 64'd1);
        n = 0;
        while (!Done && n < W + 8) begin
            if (n == W) check({tag, ".hold"}, {Hi, Lo}, old_hilo);
            @(negedge Clk);
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'(W + 1));
        check({tag, ".result"}, {Hi, Lo}, exp_hilo);
        @(negedge Clk);
        check({tag, ".pulse"}, {62'd0, Busy, Done}, 64'd0);
    endtask

    task automatic run_iter(input op_t op, input logic [31:0] a, input logic [31:0] b,
                            input string tag);
        logic [63:0] old_hilo;
        old_hilo = exp_hilo;
        exp_hilo = ref_op(op, a, b, exp_hilo);
        Start = 1'b1; Op = op; OpA = a; OpB = b;
        @(negedge Clk);
        Start = 1'b0; OpA = $urandom; OpB = $urandom;
        wait_result(tag, old_hilo);
    endtask

    task automatic run_move(input op_t op, input logic [31:0] a, input string tag);
        exp_hilo = ref_op(op, a, 32'd0, exp_hilo);
        Start = 1'b1; Op = op; OpA = a; OpB = $urandom;
        @(negedge Clk);
        Start = 1'b0;
        check({tag, ".hilo"}, {Hi, Lo}, exp_hilo);
        check({tag, ".idle"}, {62'd0, Busy, Done}, 64'd0);
    endtask

    task automatic run_unused(input op_t op, input logic [31:0] a, input logic [31:0] b,
                              input string tag);
        Start = 1'b1; Op = op; OpA = a; OpB = b;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        check({tag, ".ign_hilo"}, {Hi, Lo}, exp_hilo);
        check({tag, ".ign_busy"}, {62'd0, Busy, Done}, 64'd0);
    endtask

    task automatic issue(input op_t op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        if (tb_is_iter(op))                         run_iter(op, a, b, tag);
        else if (op == OP_MTHI || op == OP_MTLO)    run_move(op, a, tag);
        else                                        run_unused(op, a, b, tag);
    endtask

    initial begin : main
        logic [63:0] old_hilo;
        int          done_cnt;
        op_t         op;
        logic [31:0] a, b;

        Reset = 1'b1; Start = 1'b0; Op = OP_MULT; OpA = '0; OpB = '0; HiLoRead = 1'b0;
        exp_hilo = '0;
        @(negedge Clk);
        @(negedge Clk);
        check("reset.hilo", {Hi, Lo}, 64'd0);
        check("reset.flags", {61'd0, Stall, Busy, Done}, 64'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Directed arithmetic cases
        run_iter(OP_MULT, 32'hFFFF_FFFF, 32'd5, "t1_mult");
        run_iter(OP_DIVU, 32'd100, 32'd7, "t2_divu");
        run_iter(OP_DIV, 32'hFFFF_FFF9, 32'd2, "t2_div");
        run_iter(OP_DIV, 32'h0000_1234, 32'd0, "t3_div0");
        run_iter(OP_DIV, 32'hFFFF_FF00, 32'd0, "t3_div0neg");
        run_iter(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "t3_ovf");
        run_iter(OP_MULT, 32'h8000_0000, 32'h8000_0000, "t3_mulmin");

        // Stall while busy; a Start held through the op is taken only once
        // IDLE has been reached (not on the FIX->IDLE edge).
        exp_hilo = ref_op(OP_MULTU, 32'd3, 32'd4, exp_hilo);
        Start = 1'b1; Op = OP_MULTU; OpA = 32'd3; OpB = 32'd4;
        @(negedge Clk);
        Start = 1'b0;
        for (int n = 0; n <= W + 1; n++) begin
            if (n == 4) HiLoRead = 1'b1;
            if (n == 10) begin
                Start = 1'b1; Op = OP_DIVU; OpA = 32'd100; OpB = 32'd7;
            end
            #1;
            check("t4.stall", 64'(Stall), 64'(n >= 4 && n <= W));
            check("t4.busy", 64'(Busy), 64'(n <= W));
            if (n == W + 1) begin
                check("t4.done", 64'(Done), 64'd1);
                check("t4.result", {Hi, Lo}, exp_hilo);
            end
            @(negedge Clk);
        end
        Start = 1'b0; HiLoRead = 1'b0;
        old_hilo = exp_hilo;
        exp_hilo = ref_op(OP_DIVU, 32'd100, 32'd7, exp_hilo);
        wait_result("t4_held", old_hilo);

        // Asynchronous reset in the middle of a MULT
        Start = 1'b1; Op = OP_MULT; OpA = 32'($urandom); OpB = 32'($urandom) | 32'd1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("t5.rst_hilo", {Hi, Lo}, 64'd0);
        check("t5.rst_flags", {62'd0, Busy, Done}, 64'd0);
        exp_hilo = '0;
        @(negedge Clk);
        Reset = 1'b0;
        done_cnt = 0;
        repeat (W + 4) begin
            @(negedge Clk);
            if (Done) done_cnt++;
        end
        check("t5.no_done", 64'(done_cnt), 64'd0);
        run_move(OP_MTLO, 32'h0000_00A5, "t5_mtlo");

`ifdef HILO_MADD_EN
        run_move(OP_MTHI, 32'd0, "t6_mthi");
        run_move(OP_MTLO, 32'd10, "t6_mtlo");
        run_iter(OP_MADD, 32'd3, 32'd4, "t6_madd");
        run_iter(OP_MSUB, 32'd5, 32'd5, "t6_msub");
`endif

        // Randomized op stream against the reference model
        for (int i = 0; i < 60; i++) begin
            op = op_t'($urandom_range(0, 7));
            a  = rand_opnd();
            b  = rand_opnd();
            issue(op, a, b, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
